// File: rtl/alu_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_share_ctrl                                                  |
// | Desc     : Two-requester arbiter/sequencer for the shared 8-bit ALU.       |
// |            Optional macro ALU_SHARE_RR_EN selects round-robin arbitration. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_share_ctrl #(
   parameter int               CMD_W    = 5,
   parameter int               DATA_W   = 8,
   parameter logic [CMD_W-1:0] CMD_DONE = 5'b10010
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0_valid,
   input  logic [CMD_W-1:0]  req0_cmd,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   output logic              req0_ready,
   output logic              resp0_valid,
   output logic [DATA_W-1:0] resp0_rslt,
   output logic              resp0_branch,
   input  logic              resp0_ready,
   input  logic              req1_valid,
   input  logic [CMD_W-1:0]  req1_cmd,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              req1_ready,
   output logic              resp1_valid,
   output logic [DATA_W-1:0] resp1_rslt,
   output logic              resp1_branch,
   input  logic              resp1_ready,
   output logic [CMD_W-1:0]  alu_cmd,
   output logic [DATA_W-1:0] alu_inA,
   output logic [DATA_W-1:0] alu_inB,
   input  logic [DATA_W-1:0] alu_rslt,
   input  logic              alu_doBranch,
   output logic              busy,
   output logic              halted,
   output logic [15:0]       ops_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [15:0] c_ops_max = 16'hFFFF;

   state_t            r_state;
   state_t            w_state_next;
   logic [CMD_W-1:0]  r_cmd;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic              r_owner;
   logic              r_halted;
   logic [15:0]       r_ops_done;
   logic              r_resp0_valid;
   logic [DATA_W-1:0] r_resp0_rslt;
   logic              r_resp0_branch;
   logic              r_resp1_valid;
   logic [DATA_W-1:0] r_resp1_rslt;
   logic              r_resp1_branch;

   logic w_grant;
   logic w_can_grant;
   logic w_accept;
   logic w_resp_hs;

`ifdef ALU_SHARE_RR_EN
   logic r_last_grant;

   // On a tie the requester that lost the previous grant wins.
   assign w_grant = req1_valid && (!req0_valid || !r_last_grant);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant <= 1'b1;
      end else if (w_accept) begin
         r_last_grant <= w_grant;
      end
   end
`else
   assign w_grant = req1_valid && !req0_valid;
`endif

   assign w_can_grant = (r_state == IDLE) && !r_halted;
   assign req0_ready  = w_can_grant && req0_valid && !w_grant;
   assign req1_ready  = w_can_grant && req1_valid && w_grant;
   assign w_accept    = req0_ready || req1_ready;
   assign w_resp_hs   = (r_state == RESP) && (r_owner ? resp1_ready : resp0_ready);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = EXEC;
         EXEC:    w_state_next = RESP;
         RESP:    if (w_resp_hs) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cmd          <= '0;
         r_a            <= '0;
         r_b            <= '0;
         r_owner        <= 1'b0;
         r_halted       <= 1'b0;
         r_ops_done     <= '0;
         r_resp0_valid  <= 1'b0;
         r_resp0_rslt   <= '0;
         r_resp0_branch <= 1'b0;
         r_resp1_valid  <= 1'b0;
         r_resp1_rslt   <= '0;
         r_resp1_branch <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cmd   <= w_grant ? req1_cmd : req0_cmd;
            r_a     <= w_grant ? req1_a   : req0_a;
            r_b     <= w_grant ? req1_b   : req0_b;
            r_owner <= w_grant;
         end
         if (r_state == EXEC) begin
            if (r_owner) begin
               r_resp1_valid  <= 1'b1;
               r_resp1_rslt   <= alu_rslt;
               r_resp1_branch <= alu_doBranch;
            end else begin
               r_resp0_valid  <= 1'b1;
               r_resp0_rslt   <= alu_rslt;
               r_resp0_branch <= alu_doBranch;
            end
         end
         // Clearing data on completion keeps the idle response lanes at zero.
         if (w_resp_hs) begin
            r_resp0_valid  <= 1'b0;
            r_resp0_rslt   <= '0;
            r_resp0_branch <= 1'b0;
            r_resp1_valid  <= 1'b0;
            r_resp1_rslt   <= '0;
            r_resp1_branch <= 1'b0;
            if (r_ops_done != c_ops_max) begin
               r_ops_done <= r_ops_done + 16'd1;
            end
            if (r_cmd == CMD_DONE) begin
               r_halted <= 1'b1;
            end
         end
      end
   end

   assign alu_cmd      = (r_state == EXEC) ? r_cmd : '0;
   assign alu_inA      = (r_state == EXEC) ? r_a   : '0;
   assign alu_inB      = (r_state == EXEC) ? r_b   : '0;
   assign busy         = (r_state != IDLE);
   assign halted       = r_halted;
   assign ops_done     = r_ops_done;
   assign resp0_valid  = r_resp0_valid;
   assign resp0_rslt   = r_resp0_rslt;
   assign resp0_branch = r_resp0_branch;
   assign resp1_valid  = r_resp1_valid;
   assign resp1_rslt   = r_resp1_rslt;
   assign resp1_branch = r_resp1_branch;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_share_ctrl                                               |
// | Desc     : Self-checking bench for alu_share_ctrl with response scoreboard.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_alu_share_ctrl;

   localparam logic [4:0] c_add  = 5'b01000;
   localparam logic [4:0] c_sub  = 5'b01001;
   localparam logic [4:0] c_beq  = 5'b00011;
   localparam logic [4:0] c_done = 5'b10010;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [4:0] req0_cmd = '0, req1_cmd = '0;
   logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic       req0_ready, req1_ready;
   logic       resp0_valid, resp1_valid, resp0_branch, resp1_branch;
   logic [7:0] resp0_rslt, resp1_rslt;
   logic       resp0_ready = 1'b1, resp1_ready = 1'b1;
   logic [4:0] alu_cmd;
   logic [7:0] alu_inA, alu_inB, alu_rslt;
   logic       alu_doBranch;
   logic       busy, halted;
   logic [15:0] ops_done;

   typedef struct packed {
      logic       owner;
      logic       br;
      logic [7:0] rslt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t m_got, m_exp;

   always #5 clk = ~clk;

   // Reference behaviour of the shared ALU: {branch, result}.
   function automatic logic [8:0] model(input logic [4:0] c, input logic [7:0] a, input logic [7:0] b);
      case (c)
         5'b01000: return {1'b0, a + b};
         5'b01001: return {1'b0, a - b};
         5'b00011: return {(a == b), 8'h00};
         default:  return 9'h000;
      endcase
   endfunction

   assign {alu_doBranch, alu_rslt} = model(alu_cmd, alu_inA, alu_inB);

   alu_share_ctrl dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_a(req0_a), .req0_b(req0_b),
      .req0_ready(req0_ready), .resp0_valid(resp0_valid), .resp0_rslt(resp0_rslt),
      .resp0_branch(resp0_branch), .resp0_ready(resp0_ready),
      .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_a(req1_a), .req1_b(req1_b),
      .req1_ready(req1_ready), .resp1_valid(resp1_valid), .resp1_rslt(resp1_rslt),
      .resp1_branch(resp1_branch), .resp1_ready(resp1_ready),
      .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB),
      .alu_rslt(alu_rslt), .alu_doBranch(alu_doBranch),
      .busy(busy), .halted(halted), .ops_done(ops_done)
   );

   // Scoreboard: push on accept, pop on response handshake.
   always @(negedge clk) begin
      #3;
      if (reset_n) begin
         n_cmp++;
         if ((req0_ready && req1_ready) || (resp0_valid && resp1_valid)) begin
            n_bad++;
            $display("FAIL exclusivity rdy=%b%b rv=%b%b required no overlap", req0_ready, req1_ready, resp0_valid, resp1_valid);
         end
         if (req0_valid && req0_ready) sb.push_back({1'b0, model(req0_cmd, req0_a, req0_b)});
         if (req1_valid && req1_ready) sb.push_back({1'b1, model(req1_cmd, req1_a, req1_b)});
         if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
            m_got = resp1_valid ? {1'b1, resp1_branch, resp1_rslt} : {1'b0, resp0_branch, resp0_rslt};
            n_cmp++;
            if (sb.size() == 0) begin
               n_bad++;
               $display("FAIL sb_unexpected got=%h required=none", m_got);
            end else begin
               m_exp = sb.pop_front();
               if (m_got !== m_exp) begin
                  n_bad++;
                  $display("FAIL sb_resp got=%h required=%h", m_got, m_exp);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   task automatic set_req(input logic who, input logic v, input logic [4:0] c, input logic [7:0] a, input logic [7:0] b);
      if (who) begin
         req1_valid = v; req1_cmd = c; req1_a = a; req1_b = b;
      end else begin
         req0_valid = v; req0_cmd = c; req0_a = a; req0_b = b;
      end
   endtask

   task automatic drive_op(input logic who, input logic [4:0] c, input logic [7:0] a, input logic [7:0] b,
                           output logic acc, output logic got, output logic [7:0] r, output logic br);
      acc = 1'b0; got = 1'b0; r = '0; br = 1'b0;
      @(negedge clk);
      set_req(who, 1'b1, c, a, b);
      for (int i = 0; i < 8; i++) begin
         #1;
         if (who ? req1_ready : req0_ready) begin
            acc = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      set_req(who, 1'b0, 5'd0, 8'd0, 8'd0);
      if (acc) begin
         for (int i = 0; i < 8; i++) begin
            #1;
            if (who ? resp1_valid : resp0_valid) begin
               got = 1'b1;
               r   = who ? resp1_rslt : resp0_rslt;
               br  = who ? resp1_branch : resp0_branch;
               break;
            end
            @(negedge clk);
         end
      end
      @(negedge clk);
   endtask

   task automatic pulse_reset;
      @(negedge clk);
      reset_n = 1'b0;
      sb.delete();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if ({busy, halted, resp0_valid, resp1_valid, resp0_branch, resp1_branch} !== 6'b0) begin
         n_bad++;
         $display("FAIL reset_flags got=%b required=000000", {busy, halted, resp0_valid, resp1_valid, resp0_branch, resp1_branch});
      end
      n_cmp++;
      if ({ops_done, resp0_rslt, resp1_rslt, alu_cmd, alu_inA, alu_inB} !== '0) begin
         n_bad++;
         $display("FAIL reset_data ops=%h r0=%h r1=%h cmd=%h required all zero", ops_done, resp0_rslt, resp1_rslt, alu_cmd);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_add_single;
      @(negedge clk);
      set_req(1'b0, 1'b1, c_add, 8'd5, 8'd3);
      #1;
      n_cmp++;
      if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL add_ready got=%b required=1", req0_ready); end
      @(negedge clk);
      set_req(1'b0, 1'b0, 5'd0, 8'd0, 8'd0);
      #1;
      n_cmp++;
      if ({alu_cmd, alu_inA, alu_inB} !== {c_add, 8'd5, 8'd3}) begin
         n_bad++; $display("FAIL add_alu_drive got=%h/%h/%h required=08/05/03", alu_cmd, alu_inA, alu_inB);
      end
      n_cmp++;
      if ({resp0_valid, busy} !== 2'b01) begin n_bad++; $display("FAIL add_exec_state got=%b required=01", {resp0_valid, busy}); end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({resp0_valid, resp0_rslt, resp0_branch, resp1_valid} !== {1'b1, 8'd8, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL add_resp got=%b/%0d/%b/%b required=1/8/0/0", resp0_valid, resp0_rslt, resp0_branch, resp1_valid);
      end
      n_cmp++;
      if (alu_cmd !== 5'd0) begin n_bad++; $display("FAIL add_alu_nop got=%h required=00", alu_cmd); end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({ops_done, resp0_valid, busy} !== {16'd1, 1'b0, 1'b0}) begin
         n_bad++; $display("FAIL add_done got=%0d/%b/%b required=1/0/0", ops_done, resp0_valid, busy);
      end
   endtask

   task automatic test_branch;
      logic acc, got, br;
      logic [7:0] r;
      drive_op(1'b0, c_beq, 8'd7, 8'd7, acc, got, r, br);
      n_cmp++;
      if ({acc, got, br, r} !== {3'b111, 8'd0}) begin
         n_bad++; $display("FAIL beq_taken got=%b%b/%b/%0d required=11/1/0", acc, got, br, r);
      end
      drive_op(1'b0, c_beq, 8'd7, 8'd6, acc, got, r, br);
      n_cmp++;
      if ({acc, got, br, r} !== {3'b110, 8'd0}) begin
         n_bad++; $display("FAIL beq_not_taken got=%b%b/%b/%0d required=11/0/0", acc, got, br, r);
      end
      #1;
      n_cmp++;
      if (ops_done !== 16'd3) begin n_bad++; $display("FAIL beq_ops got=%0d required=3", ops_done); end
   endtask

   task automatic test_back_to_back;
      int g[$];
      int rs[$];
      int exp_g[4];
      int exp_r[4];
`ifdef ALU_SHARE_RR_EN
      exp_g = '{0, 1, 0, 1};
      exp_r = '{2, 5, 2, 5};
`else
      exp_g = '{0, 0, 0, 0};
      exp_r = '{2, 2, 2, 2};
`endif
      pulse_reset();
      @(negedge clk);
      set_req(1'b0, 1'b1, c_add, 8'd1, 8'd1);
      set_req(1'b1, 1'b1, c_sub, 8'd9, 8'd4);
      for (int c = 0; c < 12; c++) begin
         #1;
         if (req0_ready) g.push_back(0);
         if (req1_ready) g.push_back(1);
         if (resp0_valid) rs.push_back(int'(resp0_rslt));
         if (resp1_valid) rs.push_back(int'(resp1_rslt));
         @(negedge clk);
      end
      set_req(1'b0, 1'b0, 5'd0, 8'd0, 8'd0);
      set_req(1'b1, 1'b0, 5'd0, 8'd0, 8'd0);
      n_cmp++;
      if (g.size() != 4 || rs.size() != 4) begin
         n_bad++; $display("FAIL b2b_counts grants=%0d results=%0d required=4/4", g.size(), rs.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (g[i] != exp_g[i] || rs[i] != exp_r[i]) begin
               n_bad++; $display("FAIL b2b_op%0d grant=%0d rslt=%0d required=%0d/%0d", i, g[i], rs[i], exp_g[i], exp_r[i]);
            end
         end
      end
      #1;
      n_cmp++;
      if (ops_done !== 16'd4) begin n_bad++; $display("FAIL b2b_ops got=%0d required=4", ops_done); end
   endtask

   task automatic test_resp_hold;
      @(negedge clk);
      resp1_ready = 1'b0;
      set_req(1'b1, 1'b1, c_sub, 8'd10, 8'd3);
      #1;
      n_cmp++;
      if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL hold_accept got=%b required=1", req1_ready); end
      @(negedge clk);
      set_req(1'b1, 1'b0, 5'd0, 8'd0, 8'd0);
      set_req(1'b0, 1'b1, c_add, 8'd2, 8'd2);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if ({resp1_valid, resp1_rslt, busy, req0_ready, resp0_valid} !== {1'b1, 8'd7, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL hold_cycle%0d got=%b/%0d/%b/%b/%b required=1/7/1/0/0", i, resp1_valid, resp1_rslt, busy, req0_ready, resp0_valid);
         end
      end
      @(negedge clk);
      resp1_ready = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++;
      if ({resp1_valid, req0_ready} !== 2'b01) begin
         n_bad++; $display("FAIL hold_release got=%b required=01", {resp1_valid, req0_ready});
      end
      @(negedge clk);
      set_req(1'b0, 1'b0, 5'd0, 8'd0, 8'd0);
      @(negedge clk);
      #1;
      n_cmp++;
      if ({resp0_valid, resp0_rslt} !== {1'b1, 8'd4}) begin
         n_bad++; $display("FAIL hold_next got=%b/%0d required=1/4", resp0_valid, resp0_rslt);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if (ops_done !== 16'd6) begin n_bad++; $display("FAIL hold_ops got=%0d required=6", ops_done); end
   endtask

   task automatic test_reset_mid_exec;
      logic acc, got, br;
      logic [7:0] r;
      @(negedge clk);
      set_req(1'b0, 1'b1, c_add, 8'd5, 8'd3);
      @(negedge clk);
      set_req(1'b0, 1'b0, 5'd0, 8'd0, 8'd0);
      #1;
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_pre_busy got=%b required=1", busy); end
      #1;
      reset_n = 1'b0;
      sb.delete();
      #1;
      n_cmp++;
      if ({busy, halted, resp0_valid, resp1_valid, ops_done, alu_cmd} !== '0) begin
         n_bad++; $display("FAIL rst_async got=%b%b%b%b/%0d/%h required=0000/0/00", busy, halted, resp0_valid, resp1_valid, ops_done, alu_cmd);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if ({resp0_valid, busy} !== 2'b00) begin
            n_bad++; $display("FAIL rst_no_resp%0d got=%b required=00", i, {resp0_valid, busy});
         end
      end
      drive_op(1'b0, c_add, 8'd5, 8'd3, acc, got, r, br);
      #1;
      n_cmp++;
      if ({acc, got, r, br, ops_done} !== {2'b11, 8'd8, 1'b0, 16'd1}) begin
         n_bad++; $display("FAIL rst_after got=%b%b/%0d/%b/%0d required=11/8/0/1", acc, got, r, br, ops_done);
      end
   endtask

   task automatic test_halt;
      logic acc, got, br;
      logic [7:0] r;
      drive_op(1'b0, c_done, 8'd0, 8'd0, acc, got, r, br);
      #1;
      n_cmp++;
      if ({acc, got, halted, ops_done} !== {3'b111, 16'd2}) begin
         n_bad++; $display("FAIL halt_set got=%b%b/%b/%0d required=11/1/2", acc, got, halted, ops_done);
      end
      set_req(1'b1, 1'b1, c_add, 8'd1, 8'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         n_cmp++;
         if ({req1_ready, busy, halted} !== 3'b001) begin
            n_bad++; $display("FAIL halt_block%0d got=%b required=001", i, {req1_ready, busy, halted});
         end
      end
      set_req(1'b1, 1'b0, 5'd0, 8'd0, 8'd0);
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_clear got=%b required=0", halted); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_add_single();
      test_branch();
      test_back_to_back();
      test_resp_hold();
      test_reset_mid_exec();
      test_halt();
      repeat (2) @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover got=%0d required=0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
